// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction and data buses share one
// downstream port. Each requester has a one-deep pending slot, grants
// are round-robin (data first after reset), and a watchdog forces a
// completion with a poison pattern if the memory never acknowledges.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpui_request,
  input  logic [31:0] cpui_addr,
  output logic [31:0] cpui_rdata,
  output logic        cpui_ack,
  input  logic        cpud_request,
  input  logic [31:0] cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        mem_request,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err,
  output logic        protocol_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  localparam logic [31:0] POISON    = 32'hDEADBEEF;
  localparam logic [31:0] WD_LIMIT  = TIMEOUT - 1;

  logic [1:0]  state_reg;
  logic        pend_i_reg;
  logic        pend_d_reg;
  logic [31:0] pi_addr_reg;
  logic [31:0] pd_addr_reg;
  logic        pd_write_reg;
  logic [3:0]  pd_be_reg;
  logic [31:0] pd_wdata_reg;
  logic        last_d_reg;
  logic [31:0] wd_cnt_reg;

  logic granted;
  logic expire;
  logic finish;
  logic done_i;
  logic done_d;
  logic pick_d;
  logic start;

  // Completion, watchdog expiry and next-grant selection.
  always_comb begin
    granted = (state_reg != IDLE);
    expire  = granted && (TIMEOUT != 0) && !mem_ack && (wd_cnt_reg == WD_LIMIT);
    finish  = granted && (mem_ack || expire);
    done_i  = finish && (state_reg == GRANT_I);
    done_d  = finish && (state_reg == GRANT_D);
    // Data wins unless the previous grant already went to data.
    pick_d  = pend_d_reg && (!pend_i_reg || !last_d_reg);
    // One quiet cycle (the ack cycle) separates back-to-back grants.
    start   = (state_reg == IDLE) && (pend_i_reg || pend_d_reg) && !cpui_ack && !cpud_ack;
  end

  // Pending slots: capture new requests, drop and flag overlapping ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_i_reg   <= 1'b0;
      pend_d_reg   <= 1'b0;
      pi_addr_reg  <= '0;
      pd_addr_reg  <= '0;
      pd_write_reg <= 1'b0;
      pd_be_reg    <= '0;
      pd_wdata_reg <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (done_i) pend_i_reg <= 1'b0;
      if (done_d) pend_d_reg <= 1'b0;
      if (cpui_request) begin
        if (pend_i_reg) begin
          protocol_err <= 1'b1;
        end else begin
          pend_i_reg  <= 1'b1;
          pi_addr_reg <= cpui_addr;
        end
      end
      if (cpud_request) begin
        if (pend_d_reg) begin
          protocol_err <= 1'b1;
        end else begin
          pend_d_reg   <= 1'b1;
          pd_addr_reg  <= cpud_addr;
          pd_write_reg <= cpud_write;
          pd_be_reg    <= cpud_byte_enable;
          pd_wdata_reg <= cpud_wdata;
        end
      end
    end
  end

  // Grant FSM: issue the downstream command, then route the completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      last_d_reg      <= 1'b0;
      wd_cnt_reg      <= '0;
      mem_request     <= 1'b0;
      mem_addr        <= '0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_wdata       <= '0;
      cpui_ack        <= 1'b0;
      cpud_ack        <= 1'b0;
      cpui_rdata      <= '0;
      cpud_rdata      <= '0;
      timeout_err     <= 1'b0;
    end else begin
      cpui_ack    <= 1'b0;
      cpud_ack    <= 1'b0;
      mem_request <= 1'b0;
      if (state_reg == IDLE) begin
        if (start) begin
          state_reg       <= pick_d ? GRANT_D : GRANT_I;
          last_d_reg      <= pick_d;
          wd_cnt_reg      <= '0;
          mem_request     <= 1'b1;
          mem_addr        <= pick_d ? pd_addr_reg : pi_addr_reg;
          mem_write       <= pick_d && pd_write_reg;
          mem_byte_enable <= pick_d ? pd_be_reg : 4'b1111;
          mem_wdata       <= pick_d ? pd_wdata_reg : '0;
        end
      end else if (finish) begin
        state_reg <= IDLE;
        if (expire) timeout_err <= 1'b1;
        if (state_reg == GRANT_D) begin
          cpud_ack   <= 1'b1;
          cpud_rdata <= mem_ack ? mem_rdata : POISON;
        end else begin
          cpui_ack   <= 1'b1;
          cpui_rdata <= mem_ack ? mem_rdata : POISON;
        end
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected downstream
// commands and completions (with their cycle numbers); a negedge monitor
// pops and compares whenever the DUT pulses mem_request or an ack.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpui_request = 1'b0;
  logic [31:0] cpui_addr = '0;
  logic [31:0] cpui_rdata;
  logic        cpui_ack;
  logic        cpud_request = 1'b0;
  logic [31:0] cpud_addr = '0;
  logic        cpud_write = 1'b0;
  logic [3:0]  cpud_byte_enable = '0;
  logic [31:0] cpud_wdata = '0;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        timeout_err;
  logic        protocol_err;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .cpui_request(cpui_request), .cpui_addr(cpui_addr),
    .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
    .cpud_request(cpud_request), .cpud_addr(cpud_addr),
    .cpud_write(cpud_write), .cpud_byte_enable(cpud_byte_enable),
    .cpud_wdata(cpud_wdata), .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          at;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    int          at;
  } ack_exp_t;

  mem_exp_t mem_q[$];
  ack_exp_t i_q[$];
  ack_exp_t d_q[$];

  int total = 0;
  int bad = 0;

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_request) begin
        total++;
        if (mem_q.size() == 0) begin
          bad++;
          $display("FAIL mem_req_unexpected cyc=%0d addr=%h required none", cyc, mem_addr);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          if (mem_addr !== e.addr || mem_write !== e.write || mem_byte_enable !== e.be ||
              (e.chk_wdata && mem_wdata !== e.wdata) || cyc != e.at) begin
            bad++;
            $display("FAIL mem_req got cyc=%0d a=%h w=%b be=%b d=%h required cyc=%0d a=%h w=%b be=%b d=%h",
                     cyc, mem_addr, mem_write, mem_byte_enable, mem_wdata,
                     e.at, e.addr, e.write, e.be, e.wdata);
          end
        end
      end
      if (cpui_ack) begin
        total++;
        if (i_q.size() == 0) begin
          bad++;
          $display("FAIL cpui_ack_unexpected cyc=%0d rdata=%h required none", cyc, cpui_rdata);
        end else begin
          ack_exp_t a;
          a = i_q.pop_front();
          if (cpui_rdata !== a.data || cyc != a.at) begin
            bad++;
            $display("FAIL cpui_ack got cyc=%0d rdata=%h required cyc=%0d rdata=%h",
                     cyc, cpui_rdata, a.at, a.data);
          end
        end
      end
      if (cpud_ack) begin
        total++;
        if (d_q.size() == 0) begin
          bad++;
          $display("FAIL cpud_ack_unexpected cyc=%0d rdata=%h required none", cyc, cpud_rdata);
        end else begin
          ack_exp_t a;
          a = d_q.pop_front();
          if (cpud_rdata !== a.data || cyc != a.at) begin
            bad++;
            $display("FAIL cpud_ack got cyc=%0d rdata=%h required cyc=%0d rdata=%h",
                     cyc, cpud_rdata, a.at, a.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end else begin
      $display("check %s = %b", name, got);
    end
  endtask

  task automatic check_zero(input string name);
    logic [137:0] v;
    v = {cpui_rdata, cpui_ack, cpud_rdata, cpud_ack, mem_request, mem_addr,
         mem_write, mem_byte_enable, mem_wdata, timeout_err, protocol_err};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s outputs got=%h required=0", name, v);
    end else begin
      $display("check %s outputs all zero", name);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] d, input logic chk, input int at);
    mem_exp_t e;
    e.addr = a; e.write = w; e.be = be; e.wdata = d; e.chk_wdata = chk; e.at = at;
    mem_q.push_back(e);
  endtask

  task automatic push_ack(input logic is_d, input logic [31:0] d, input int at);
    ack_exp_t a;
    a.data = d; a.at = at;
    if (is_d) d_q.push_back(a);
    else i_q.push_back(a);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    #1;
    check_zero(name);
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_ack(input logic [31:0] d);
    mem_ack = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack = 1'b0;
  endtask

  int n;

  initial begin
    do_reset("reset_initial");

    // Single data read: request N, mem_request N+2, ack N+5 -> cpud_ack N+6.
    n = cyc;
    push_mem(32'h1000, 1'b0, 4'hF, 32'h0, 1'b1, n + 2);
    push_ack(1'b1, 32'h12345678, n + 6);
    cpud_request = 1'b1; cpud_addr = 32'h1000; cpud_write = 1'b0;
    cpud_byte_enable = 4'hF; cpud_wdata = 32'h0;
    tick();
    cpud_request = 1'b0;
    wait_to(n + 5);
    pulse_ack(32'h12345678);
    wait_to(n + 9);
    check_bit("cpud_rdata_hold", cpud_rdata == 32'h12345678, 1'b1);

    // Simultaneous requests after reset: data first, instruction 2 cycles after cpud_ack.
    do_reset("reset_before_simul");
    n = cyc;
    push_mem(32'h2000, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b1, n + 2);
    push_ack(1'b1, 32'h11111111, n + 4);
    push_mem(32'h0, 1'b0, 4'hF, 32'h0, 1'b0, n + 6);
    push_ack(1'b0, 32'h22222222, n + 8);
    cpui_request = 1'b1; cpui_addr = 32'h0;
    cpud_request = 1'b1; cpud_addr = 32'h2000; cpud_write = 1'b1;
    cpud_byte_enable = 4'b0011; cpud_wdata = 32'hAABBCCDD;
    tick();
    cpui_request = 1'b0; cpud_request = 1'b0; cpud_write = 1'b0;
    wait_to(n + 3);
    pulse_ack(32'h11111111);
    wait_to(n + 7);
    pulse_ack(32'h22222222);
    wait_to(n + 10);

    // Sustained contention: each requester re-requests on its own ack cycle.
    n = cyc;
    for (int k = 0; k < 6; k++) begin
      push_mem((k % 2 == 0) ? 32'h3000 + k : 32'h4000 + k, 1'b0, 4'hF, 32'h0,
               (k % 2 == 0), n + 2 + 4 * k);
      push_ack(k % 2 == 0, 32'h50000000 + k, n + 4 + 4 * k);
    end
    cpud_request = 1'b1; cpud_addr = 32'h3000; cpud_write = 1'b0;
    cpud_byte_enable = 4'hF; cpud_wdata = 32'h0;
    cpui_request = 1'b1; cpui_addr = 32'h4001;
    tick();
    cpud_request = 1'b0; cpui_request = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_to(n + 3 + 4 * k);
      pulse_ack(32'h50000000 + k);
      if (k < 4) begin
        if (k % 2 == 0) begin
          cpud_request = 1'b1; cpud_addr = 32'h3000 + k + 2;
        end else begin
          cpui_request = 1'b1; cpui_addr = 32'h4000 + k + 2;
        end
        tick();
        cpud_request = 1'b0; cpui_request = 1'b0;
      end
    end
    wait_to(n + 30);
    check_bit("no_protocol_err_contention", protocol_err, 1'b0);

    // Watchdog: ack withheld, forced completion 8 cycles after mem_request.
    do_reset("reset_before_timeout");
    n = cyc;
    push_mem(32'h5000, 1'b0, 4'hF, 32'h0, 1'b0, n + 2);
    push_ack(1'b0, 32'hDEADBEEF, n + 10);
    cpui_request = 1'b1; cpui_addr = 32'h5000;
    tick();
    cpui_request = 1'b0;
    wait_to(n + 9);
    check_bit("timeout_err_before", timeout_err, 1'b0);
    wait_to(n + 12);
    pulse_ack(32'h0BAD0BAD);
    wait_to(n + 16);
    check_bit("timeout_err_sticky", timeout_err, 1'b1);

    // Overlapping data request: dropped, flagged, first one completes.
    do_reset("reset_before_protocol");
    n = cyc;
    push_mem(32'h6000, 1'b0, 4'hF, 32'h0, 1'b1, n + 2);
    push_ack(1'b1, 32'h00000099, n + 5);
    cpud_request = 1'b1; cpud_addr = 32'h6000; cpud_write = 1'b0;
    cpud_byte_enable = 4'hF; cpud_wdata = 32'h0;
    tick();
    cpud_addr = 32'h7000;
    check_bit("protocol_err_before", protocol_err, 1'b0);
    tick();
    cpud_request = 1'b0;
    check_bit("protocol_err_set", protocol_err, 1'b1);
    wait_to(n + 4);
    pulse_ack(32'h00000099);
    wait_to(n + 12);
    check_bit("protocol_err_sticky", protocol_err, 1'b1);

    // Reset during GRANT_D, then a stray mem_ack after release.
    do_reset("reset_before_abort");
    n = cyc;
    push_mem(32'h8000, 1'b0, 4'hF, 32'h0, 1'b1, n + 2);
    cpud_request = 1'b1; cpud_addr = 32'h8000;
    tick();
    cpud_request = 1'b0;
    wait_to(n + 3);
    do_reset("reset_mid_grant");
    pulse_ack(32'hCAFEF00D);
    repeat (4) tick();
    check_zero("after_abort");
    n = cyc;
    push_mem(32'h9000, 1'b0, 4'hF, 32'h0, 1'b0, n + 2);
    push_ack(1'b0, 32'h00000077, n + 4);
    cpui_request = 1'b1; cpui_addr = 32'h9000;
    tick();
    cpui_request = 1'b0;
    wait_to(n + 3);
    pulse_ack(32'h00000077);
    wait_to(n + 8);

    total++;
    if (mem_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0) begin
      bad++;
      $display("FAIL queues_drained got mem=%0d i=%0d d=%0d required 0 0 0",
               mem_q.size(), i_q.size(), d_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
